mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit_if.sv | 30 +++
 rtl/mult_div_unit.sv | 135 +++++++++++++
 tb/tb_mult_div_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/response bundle between the control unit and the
// iterative multiply/divide unit.
//   start_mult, start_div : one-cycle operation requests (control -> unit)
//   op_a, op_b            : rs / rt operands, valid on the accepting edge
//   busy, done            : unit status; done is a one-cycle completion pulse
//   div_zero              : last accepted divide had a zero divisor
//   hi, lo                : architectural HI/LO registers
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_mult, start_div, op_a, op_b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start_mult, start_div, op_a, op_b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply (shift-add) and divide (restoring)
// for the multicycle MIPS core. Owns HI/LO.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mult_div_unit_if.slave (start_mult/start_div/op_a/op_b in,
//          busy/done/div_zero/hi/lo out)
// Both operations run on magnitudes for WIDTH cycles; signs are reapplied on
// the completing edge. Multiply wins if both starts arrive together.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  mult_div_unit_if.slave     bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  // Shared working register: upper half is the running product high part
  // (mult) or partial remainder (div); lower half holds the multiplier being
  // shifted out (mult) or the dividend shifting into the quotient (div).
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb_mag;
  logic               neg_q;   // negate product / quotient
  logic               neg_r;   // negate remainder (dividend sign)
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               a_neg, b_neg;

  assign a_neg = bus.op_a[WIDTH-1];
  assign b_neg = bus.op_b[WIDTH-1];
  // |-2^(W-1)| is 2^(W-1), which is still representable unsigned.
  assign a_mag = a_neg ? -bus.op_a : bus.op_a;
  assign b_mag = b_neg ? -bus.op_b : bus.op_b;

  // Multiply step: conditionally add multiplicand into upper half, then
  // shift the whole accumulator right, keeping the carry.
  logic [WIDTH:0]     madd;
  logic [2*WIDTH-1:0] mult_nxt;
  assign madd     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb_mag} : '0);
  assign mult_nxt = {madd, acc[WIDTH-1:1]};

  // Restoring divide step: shift remainder left pulling in the next dividend
  // bit, trial-subtract the divisor; a clear top bit means it fit.
  logic [WIDTH:0]     dshift, dtrial;
  logic               dfit;
  logic [2*WIDTH-1:0] div_nxt;
  assign dshift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign dtrial  = dshift - {1'b0, opb_mag};
  assign dfit    = ~dtrial[WIDTH];
  assign div_nxt = {(dfit ? dtrial[WIDTH-1:0] : dshift[WIDTH-1:0]),
                    acc[WIDTH-2:0], dfit};

  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quot_res, rem_res;
  assign prod_res = neg_q ? -mult_nxt : mult_nxt;
  assign quot_res = neg_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
  assign rem_res  = neg_r ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opb_mag <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_mult) begin
            acc     <= {{WIDTH{1'b0}}, a_mag};
            opb_mag <= b_mag;
            neg_q   <= a_neg ^ b_neg;
            dz_q    <= 1'b0;
            cnt     <= '0;
            state   <= S_MULT;
          end else if (bus.start_div) begin
            if (bus.op_b != '0) begin
              acc     <= {{WIDTH{1'b0}}, a_mag};
              opb_mag <= b_mag;
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
              dz_q    <= 1'b0;
              cnt     <= '0;
              state   <= S_DIV;
            end else begin
              // HI/LO deliberately untouched on a zero divisor.
              dz_q  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_MULT: begin
          acc <= mult_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi_q  <= prod_res[2*WIDTH-1:WIDTH];
            lo_q  <= prod_res[WIDTH-1:0];
            state <= S_DONE;
          end
        end
        S_DIV: begin
          acc <= div_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi_q  <= rem_res;
            lo_q  <= quot_res;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;  // S_DONE
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus();
  mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Issue one request, return at the negedge of the done cycle (or after the
  // cycle budget). bcyc counts busy cycles after the accepting edge.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, output int bcyc,
                        output logic dz0, output logic gotd);
    bus.start_mult = m; bus.start_div = d; bus.op_a = a; bus.op_b = b;
    @(posedge clk);  // E0
    #1;
    bus.start_mult = 1'b0; bus.start_div = 1'b0;
    bus.op_a = 32'hDEADBEEF; bus.op_b = 32'h0;  // operands must be latched
    dz0 = bus.div_zero;
    bcyc = 0; gotd = 1'b0;
    for (int i = 0; i < 100 && !gotd; i++) begin
      @(negedge clk);
      if (bus.busy) bcyc++;
      if (bus.done) gotd = 1'b1;
    end
  endtask

  task automatic op_check(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
    int bc; logic dz0, gd;
    run_op(m, d, a, b, bc, dz0, gd);
    chk({tag, " done"}, 64'(gd), 64'd1);
    chk({tag, " hi"}, 64'(bus.hi), 64'(ehi));
    chk({tag, " lo"}, 64'(bus.lo), 64'(elo));
    @(negedge clk);
    chk({tag, " done pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int bc, nd;
    logic dz0, gd;
    logic [31:0] lo_at_done, hi_at_done;
    bus.start_mult = 1'b0; bus.start_div = 1'b0;
    bus.op_a = '0; bus.op_b = '0;

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst dz", 64'(bus.div_zero), 64'd0);
    chk("rst hi", 64'(bus.hi), 64'd0);
    chk("rst lo", 64'(bus.lo), 64'd0);

    // 7 x -3 with timing
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, bc, dz0, gd);
    chk("m7x-3 done", 64'(gd), 64'd1);
    chk("m7x-3 busy cycles", 64'(bc), 64'd33);
    chk("m7x-3 hi", 64'(bus.hi), 64'hFFFFFFFF);
    chk("m7x-3 lo", 64'(bus.lo), 64'hFFFFFFEB);
    @(negedge clk);
    chk("m7x-3 done pulse", 64'(bus.done), 64'd0);
    chk("m7x-3 idle", 64'(bus.busy), 64'd0);

    op_check("m min*min", 1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    op_check("m -1*-1",   1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
    op_check("d -7/2",    1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op_check("d 7/-2",    1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);
    op_check("d min/-1",  1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    // 0x451 / 0x20 = 0x22 rem 0x11 : preload HI/LO
    op_check("d preload", 1'b0, 1'b1, 32'h451, 32'h20, 32'h11, 32'h22);

    // divide by zero
    run_op(1'b0, 1'b1, 32'd5, 32'd0, bc, dz0, gd);
    chk("dz done", 64'(gd), 64'd1);
    chk("dz busy cycles", 64'(bc), 64'd1);
    chk("dz flag", 64'(bus.div_zero), 64'd1);
    chk("dz hi held", 64'(bus.hi), 64'h11);
    chk("dz lo held", 64'(bus.lo), 64'h22);
    @(negedge clk);
    chk("dz flag holds", 64'(bus.div_zero), 64'd1);
    chk("dz idle", 64'(bus.busy), 64'd0);
    run_op(1'b1, 1'b0, 32'd6, 32'd2, bc, dz0, gd);
    chk("6x2 dz cleared at E0", 64'(dz0), 64'd0);
    chk("6x2 done", 64'(gd), 64'd1);
    chk("6x2 lo", 64'(bus.lo), 64'd12);
    chk("6x2 hi", 64'(bus.hi), 64'd0);
    @(negedge clk);

    // both starts; divide pulsed mid-operation is ignored
    bus.start_mult = 1'b1; bus.start_div = 1'b1; bus.op_a = 32'd6; bus.op_b = 32'd3;
    @(posedge clk);  // E0
    #1 bus.start_mult = 1'b0; bus.start_div = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.start_div = 1'b1; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(posedge clk);  // E10
    #1 bus.start_div = 1'b0;
    nd = 0; lo_at_done = '0; hi_at_done = '1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) begin nd++; lo_at_done = bus.lo; hi_at_done = bus.hi; end
    end
    chk("both one done", 64'(nd), 64'd1);
    chk("both lo", 64'(lo_at_done), 64'd18);
    chk("both hi", 64'(hi_at_done), 64'd0);
    chk("both idle", 64'(bus.busy), 64'd0);

    // reset mid-multiply
    bus.start_mult = 1'b1; bus.op_a = 32'h1234; bus.op_b = 32'h5678;
    @(posedge clk);  // E0
    #1 bus.start_mult = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);  // E10
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst mid busy", 64'(bus.busy), 64'd0);
    chk("rst mid hi", 64'(bus.hi), 64'd0);
    chk("rst mid lo", 64'(bus.lo), 64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("rst mid no done", 64'(nd), 64'd0);
    op_check("m 2x2", 1'b1, 1'b0, 32'd2, 32'd2, 32'd0, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
